// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter for the regfile write port with RAW scoreboard and forward path
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_wa,
    input  logic [XLEN*NREQ-1:0] req_wd,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 rsv_valid,
    input  logic [4:0]           rsv_wa,
    output logic                 rf_write,
    output logic [4:0]           rf_wa,
    output logic [XLEN-1:0]      rf_wd,
    input  logic [4:0]           q_ra1,
    input  logic [4:0]           q_ra2,
    output logic                 q_busy1,
    output logic                 q_busy2,
    output logic                 q_fwd1,
    output logic                 q_fwd2,
    output logic [XLEN-1:0]      q_fwd_data
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_q, rr_d;
    logic            rf_write_q, rf_write_d;
    logic [4:0]      rf_wa_q;
    logic [XLEN-1:0] rf_wd_q;
    logic [31:0]     busy_q, busy_d;

    logic            found;
    logic            xfer;
    logic [PW-1:0]   gnt;
    logic [PW:0]     cand;
    logic [PW-1:0]   idx;
    logic [4:0]      gnt_wa;
    logic [XLEN-1:0] gnt_wd;

    // Rotating priority search starting at the round-robin pointer.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        cand  = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            idx = cand[PW-1:0];
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    assign xfer = found && rst_n;

    always_comb begin
        req_ready = '0;
        gnt_wa    = '0;
        gnt_wd    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == PW'(i)) begin
                req_ready[i] = xfer;
                gnt_wa       = req_wa[5*i +: 5];
                gnt_wd       = req_wd[XLEN*i +: XLEN];
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (xfer) begin
            rr_d = (gnt == PW'(NREQ-1)) ? '0 : gnt + PW'(1);
        end
        rf_write_d = xfer && (gnt_wa != 5'd0);
        // Clear before set so a same-cycle reservation by a newer producer wins.
        busy_d = busy_q;
        if (rf_write_d) begin
            busy_d[gnt_wa] = 1'b0;
        end
        if (rsv_valid && (rsv_wa != 5'd0)) begin
            busy_d[rsv_wa] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= '0;
            rf_write_q <= 1'b0;
            rf_wa_q    <= '0;
            rf_wd_q    <= '0;
            busy_q     <= '0;
        end else begin
            rr_q       <= rr_d;
            rf_write_q <= rf_write_d;
            busy_q     <= busy_d;
            if (rf_write_d) begin
                rf_wa_q <= gnt_wa;
                rf_wd_q <= gnt_wd;
            end
        end
    end

    assign rf_write   = rf_write_q;
    assign rf_wa      = rf_wa_q;
    assign rf_wd      = rf_wd_q;
    assign q_busy1    = (q_ra1 != 5'd0) && busy_q[q_ra1];
    assign q_busy2    = (q_ra2 != 5'd0) && busy_q[q_ra2];
    assign q_fwd1     = rf_write_q && (rf_wa_q == q_ra1) && (q_ra1 != 5'd0);
    assign q_fwd2     = rf_write_q && (rf_wa_q == q_ra2) && (q_ra2 != 5'd0);
    assign q_fwd_data = rf_wd_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter against a queue/array reference model
module tb_regfile_wb_arbiter;
    localparam int NREQ = 3;
    localparam int XLEN = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [5*NREQ-1:0]    req_wa;
    logic [XLEN*NREQ-1:0] req_wd;
    logic [NREQ-1:0]      req_ready;
    logic                 rsv_valid;
    logic [4:0]           rsv_wa;
    logic                 rf_write;
    logic [4:0]           rf_wa;
    logic [XLEN-1:0]      rf_wd;
    logic [4:0]           q_ra1, q_ra2;
    logic                 q_busy1, q_busy2, q_fwd1, q_fwd2;
    logic [XLEN-1:0]      q_fwd_data;

    regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_wa(req_wa), .req_wd(req_wd), .req_ready(req_ready),
        .rsv_valid(rsv_valid), .rsv_wa(rsv_wa),
        .rf_write(rf_write), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .q_ra1(q_ra1), .q_ra2(q_ra2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .q_fwd1(q_fwd1), .q_fwd2(q_fwd2), .q_fwd_data(q_fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    int  errors = 0;
    int  checks = 0;
    wr_t exp_q[$];
    int  gnt_log[$];

    // Reference model state
    int          rr_m;
    bit          busy_m[32];
    bit          inf_w;
    logic [4:0]  inf_wa;
    logic [31:0] inf_wd;

    // Requester-side pending writebacks
    bit          pv[NREQ];
    logic [4:0]  pwa[NREQ];
    logic [31:0] pwd[NREQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]             = pv[i];
            req_wa[5*i +: 5]         = pwa[i];
            req_wd[XLEN*i +: XLEN]   = pwd[i];
        end
    endtask

    task automatic model_reset();
        rr_m   = 0;
        inf_w  = 1'b0;
        inf_wa = '0;
        inf_wd = '0;
        for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle: entered just after a falling edge with stimulus staged.
    task automatic step();
        int  g;
        wr_t e;
        drive();
        #1;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && pv[(rr_m + k) % NREQ]) g = (rr_m + k) % NREQ;
        end
        chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
        chk("q_busy1", q_busy1, (q_ra1 != 0) && busy_m[q_ra1]);
        chk("q_busy2", q_busy2, (q_ra2 != 0) && busy_m[q_ra2]);
        chk("q_fwd1", q_fwd1, inf_w && (inf_wa == q_ra1) && (q_ra1 != 0));
        chk("q_fwd2", q_fwd2, inf_w && (inf_wa == q_ra2) && (q_ra2 != 0));
        if (inf_w) chk("q_fwd_data", q_fwd_data, inf_wd);
        e.w  = (g >= 0) && (pwa[(g < 0) ? 0 : g] != 0);
        e.wa = (g >= 0) ? pwa[g] : 5'd0;
        e.wd = (g >= 0) ? pwd[g] : 32'd0;
        exp_q.push_back(e);
        @(posedge clk);
        if (g >= 0) begin
            gnt_log.push_back(g);
            if (pwa[g] != 0) busy_m[pwa[g]] = 1'b0;
            rr_m  = (g + 1) % NREQ;
            pv[g] = 1'b0;
        end
        if (rsv_valid && rsv_wa != 0) busy_m[rsv_wa] = 1'b1;
        inf_w = e.w;
        if (e.w) begin
            inf_wa = e.wa;
            inf_wd = e.wd;
        end
        @(negedge clk);
    endtask

    // Monitor: the write port is presented every cycle, one expectation per cycle.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_write", rf_write, e.w);
                if (e.w) begin
                    chk("rf_wa", rf_wa, e.wa);
                    chk("rf_wd", rf_wd, e.wd);
                end
            end
        end
    end

    initial begin
        int exp_order[6] = '{0, 1, 2, 0, 1, 2};

        model_reset();
        rst_n     = 1'b0;
        rsv_valid = 1'b0;
        rsv_wa    = '0;
        q_ra1     = '0;
        q_ra2     = '0;
        req_valid = '1;
        req_wa    = '0;
        req_wd    = '0;
        #2;
        chk("reset_rf_write", rf_write, 0);
        chk("reset_rf_wa", rf_wa, 0);
        chk("reset_rf_wd", rf_wd, 0);
        chk("reset_req_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin with all requesters continuously valid
        gnt_log.delete();
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i]) begin
                    pv[i]  = 1'b1;
                    pwa[i] = 5'(10 + i);
                    pwd[i] = $urandom;
                end
            end
            step();
        end
        chk("rr_count", gnt_log.size(), 6);
        for (int i = 0; i < 6; i++) chk("rr_order", gnt_log[i], exp_order[i]);
        for (int n = 0; n < 3; n++) step();

        // Single request
        pv[0] = 1'b1; pwa[0] = 5'd5; pwd[0] = 32'hDEADBEEF;
        step();
        chk("single_write", rf_write, 1);
        chk("single_wa", rf_wa, 5);
        chk("single_wd", rf_wd, 32'hDEADBEEF);
        step();

        // x0 destination is consumed but never written
        pv[1] = 1'b1; pwa[1] = 5'd0; pwd[1] = 32'h1234;
        step();
        chk("x0_write", rf_write, 0);
        for (int i = 0; i < NREQ; i++) begin
            pv[i] = 1'b1; pwa[i] = 5'(20 + i); pwd[i] = $urandom;
        end
        step();
        chk("x0_rr_next", gnt_log[gnt_log.size()-1], 2);
        for (int n = 0; n < 3; n++) step();

        // Scoreboard, forwarding and same-cycle set-over-clear
        q_ra1 = 5'd7; q_ra2 = 5'd0;
        rsv_valid = 1'b1; rsv_wa = 5'd7;
        step();
        rsv_valid = 1'b0;
        step();
        chk("sb_busy_x7", q_busy1, 1);
        pv[2] = 1'b1; pwa[2] = 5'd7; pwd[2] = 32'h7777_0007;
        step();
        chk("sb_cleared", q_busy1, 0);
        chk("sb_fwd", q_fwd1, 1);
        chk("sb_fwd_data", q_fwd_data, 32'h7777_0007);
        step();
        rsv_valid = 1'b1; rsv_wa = 5'd7;
        step();
        pv[2] = 1'b1; pwa[2] = 5'd7; pwd[2] = 32'h7777_0017;
        step();
        rsv_valid = 1'b0;
        step();
        chk("sb_set_wins", q_busy1, 1);

        // Back-pressure: requester 1 holds its payload until granted
        pv[0] = 1'b1; pwa[0] = 5'd3; pwd[0] = 32'h0303_0303;
        pv[1] = 1'b1; pwa[1] = 5'd9; pwd[1] = 32'hA5A5A5A5;
        for (int n = 0; n < 3; n++) step();

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < NREQ; i++) begin
            pv[i] = 1'b1; pwa[i] = 5'(12 + i); pwd[i] = $urandom;
        end
        rsv_valid = 1'b1; rsv_wa = 5'd12;
        step();
        rsv_valid = 1'b0;
        q_ra1 = 5'd12; q_ra2 = 5'd13;
        drive();
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_rf_write", rf_write, 0);
        chk("mid_reset_req_ready", req_ready, 0);
        chk("mid_reset_busy1", q_busy1, 0);
        chk("mid_reset_busy2", q_busy2, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(0, 2) != 0) begin
                    pv[i]  = 1'b1;
                    pwa[i] = 5'($urandom_range(0, 9));
                    pwd[i] = $urandom;
                end
            end
            rsv_valid = ($urandom_range(0, 2) == 0);
            rsv_wa    = 5'($urandom_range(0, 9));
            q_ra1     = 5'($urandom_range(0, 9));
            q_ra2     = 5'($urandom_range(0, 9));
            step();
        end
        rsv_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        step();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
